// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA modular-multiply responder.
package rsa_pkg;

  // Responder FSM states, in the order an operation walks through them.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    CALC  = 3'd2,
    DONE  = 3'd3,
    REARM = 3'd4
  } state_t;

  // Default operand width and bit-counter width (2**CNT_W must cover WIDTH).
  localparam int WIDTH_DEFAULT = 4096;
  localparam int CNT_W_DEFAULT = 12;

  // Accept edge to ready-visible edge, in clock cycles, for the default width.
  localparam int LATENCY = WIDTH_DEFAULT + 2;

  // Same latency figure for any other operand width.
  function automatic int latency_for(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/mod_mult_resp_if.sv
// Start/ready multiply handshake between the ladder controller and the responder.
interface mod_mult_resp_if #(
  parameter int WIDTH = rsa_pkg::WIDTH_DEFAULT
) ();

  logic             start;
  logic [WIDTH-1:0] X_data;
  logic [WIDTH-1:0] Y_data;
  logic [WIDTH-1:0] N;
  logic             ready;
  logic [WIDTH-1:0] result;
  logic             err;

  // Requester side: raises start with operands, waits for ready.
  modport master (
    output start, X_data, Y_data, N,
    input  ready, result, err
  );

  // Responder side: the modular multiplier.
  modport slave (
    input  start, X_data, Y_data, N,
    output ready, result, err
  );

endinterface

// File: rtl/mod_mult_step.sv
// One MSB-first interleaved radix-2 iteration: returns (2P + bit*A) mod N.
// Requires P < N and A < N; the result is again < N.
module mod_mult_step #(
  parameter int WIDTH = rsa_pkg::WIDTH_DEFAULT
) (
  input  logic [WIDTH:0]   p,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] n,
  input  logic             b_bit,
  output logic [WIDTH:0]   p_next
);

  logic [WIDTH+1:0] dbl;
  logic [WIDTH+1:0] n_wide;
  logic [WIDTH:0]   n_ext;
  logic [WIDTH:0]   red1;
  logic [WIDTH:0]   sum;

  // Double, reduce once, conditionally add A, reduce once more.
  // Both 2P and red1+A are below 2N, so a single subtract per stage suffices.
  always_comb begin
    dbl    = {p, 1'b0};
    n_wide = {2'b00, n};
    n_ext  = {1'b0, n};
    if (dbl >= n_wide) begin
      red1 = (WIDTH+1)'(dbl - n_wide);
    end else begin
      red1 = (WIDTH+1)'(dbl);
    end
    sum = b_bit ? (red1 + {1'b0, a}) : red1;
    if (sum >= n_ext) begin
      p_next = sum - n_ext;
    end else begin
      p_next = sum;
    end
  end

endmodule

// File: rtl/mod_mult_resp.sv
// Responder for the ladder's multiply request: result = (X_data * Y_data) mod N,
// one multiplier bit per clock, fixed latency WIDTH+2 from the accept edge.
module mod_mult_resp
  import rsa_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  mod_mult_resp_if.slave bus
);

  localparam int IDX_W = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH:0]   p_step;
  logic [CNT_W-1:0] count_q, count_d;
  logic             flag_q, flag_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             operands_bad;
  logic             b_bit;

  // Operands that would break the P < N invariant, or a zero modulus.
  assign operands_bad = (n_q == '0) || (a_q >= n_q) || (b_q >= n_q);
  assign b_bit        = b_q[count_q[IDX_W-1:0]];

  mod_mult_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .p      (p_q),
    .a      (a_q),
    .n      (n_q),
    .b_bit  (b_bit),
    .p_next (p_step)
  );

  assign bus.ready  = ready_q;
  assign bus.err    = err_q;
  assign bus.result = result_q;

  // State register; reset aborts any operation in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      n_q      <= '0;
      p_q      <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      n_q      <= n_d;
      p_q      <= p_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  // Next-state logic. REARM waits for start to drop so a held request
  // never launches a second operation.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = CHECK;
      CHECK:   state_d = operands_bad ? DONE : CALC;
      CALC:    if (count_q == '0) state_d = DONE;
      DONE:    state_d = REARM;
      REARM:   if (!bus.start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath updates and registered outputs for each state.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    n_d      = n_q;
    p_d      = p_q;
    count_d  = count_q;
    flag_d   = flag_q;
    ready_d  = 1'b0;
    err_d    = err_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d    = bus.X_data;
          b_d    = bus.Y_data;
          n_d    = bus.N;
          flag_d = 1'b0;
          err_d  = 1'b0;
        end
      end
      CHECK: begin
        flag_d  = operands_bad;
        p_d     = '0;
        count_d = CNT_W'(WIDTH - 1);
      end
      CALC: begin
        p_d = p_step;
        if (count_q != '0) begin
          count_d = count_q - 1'b1;
        end
      end
      DONE: begin
        ready_d  = 1'b1;
        err_d    = flag_q;
        result_d = flag_q ? '0 : p_q[WIDTH-1:0];
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mod_mult_resp.sv
// Self-checking bench for mod_mult_resp: directed WIDTH=8 cases plus a
// WIDTH=64 random sweep against a reference (A*B)%N model.
module tb_mod_mult_resp;
  import rsa_pkg::*;

  localparam int W8  = 8;
  localparam int W64 = 64;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] n;
    logic [63:0] res;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  int vectors     = 0;
  int miscompares = 0;

  exp_t q8[$];
  exp_t q64[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mod_mult_resp_if #(.WIDTH(W8))  bus8 ();
  mod_mult_resp_if #(.WIDTH(W64)) bus64 ();

  mod_mult_resp #(.WIDTH(W8), .CNT_W(3)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  mod_mult_resp #(.WIDTH(W64), .CNT_W(6)) dut64 (
    .clk (clk),
    .rst (rst),
    .bus (bus64.slave)
  );

  // Drive a WIDTH=8 request (call at a negedge) and push its expectation.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] n);
    exp_t e;
    e.a   = 64'(a);
    e.b   = 64'(b);
    e.n   = 64'(n);
    e.err = (n == 8'd0) || (a >= n) || (b >= n);
    e.res = e.err ? 64'd0 : ((64'(a) * 64'(b)) % 64'(n));
    e.lat = e.err ? 2 : latency_for(W8);
    e.acc = cyc + 1;
    bus8.X_data = a;
    bus8.Y_data = b;
    bus8.N      = n;
    bus8.start  = 1'b1;
    q8.push_back(e);
  endtask

  task automatic wait_ready8(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus8.ready === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_ready64(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus64.ready === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors += 6;
    if (bus8.ready !== 1'b0) begin
      miscompares++; $display("FAIL reset_ready8: got %b want 0", bus8.ready);
    end
    if (bus8.err !== 1'b0) begin
      miscompares++; $display("FAIL reset_err8: got %b want 0", bus8.err);
    end
    if (bus8.result !== 8'd0) begin
      miscompares++; $display("FAIL reset_result8: got %0d want 0", bus8.result);
    end
    if (bus64.ready !== 1'b0) begin
      miscompares++; $display("FAIL reset_ready64: got %b want 0", bus64.ready);
    end
    if (bus64.err !== 1'b0) begin
      miscompares++; $display("FAIL reset_err64: got %b want 0", bus64.err);
    end
    if (bus64.result !== 64'd0) begin
      miscompares++; $display("FAIL reset_result64: got %0d want 0", bus64.result);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Valid and invalid operand tables; each op is checked for result, err,
  // latency and a single-cycle ready pulse.
  task automatic test_directed();
    logic [7:0] ta [0:11] = '{8'd7, 8'd12, 8'd0, 8'd9, 8'd1,   8'd250, 8'd254, 8'd100, 8'd5, 8'd20, 8'd3,  8'd13};
    logic [7:0] tb [0:11] = '{8'd5, 8'd12, 8'd9, 8'd0, 8'd200, 8'd250, 8'd254, 8'd3,   8'd5, 8'd3,  8'd13, 8'd2};
    logic [7:0] tn [0:11] = '{8'd13, 8'd13, 8'd13, 8'd13, 8'd251, 8'd251, 8'd255, 8'd128, 8'd0, 8'd13, 8'd13, 8'd13};
    bit   ok;
    exp_t e;
    for (int k = 0; k < 12; k++) begin
      issue8(ta[k], tb[k], tn[k]);
      wait_ready8(ok);
      bus8.start = 1'b0;
      e = q8.pop_front();
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL directed_timeout: op %0d no ready within bound", k);
        continue;
      end
      $display("op8 A=%0d B=%0d N=%0d -> result=%0d err=%b lat=%0d",
               e.a, e.b, e.n, bus8.result, bus8.err, cyc - e.acc);
      vectors += 3;
      if (bus8.result !== e.res[7:0]) begin
        miscompares++; $display("FAIL directed_result: got %0d want %0d", bus8.result, e.res);
      end
      if (bus8.err !== e.err) begin
        miscompares++; $display("FAIL directed_err: got %b want %b", bus8.err, e.err);
      end
      if (cyc - e.acc != e.lat) begin
        miscompares++; $display("FAIL directed_latency: got %0d want %0d", cyc - e.acc, e.lat);
      end
      @(negedge clk);
      vectors++;
      if (bus8.ready !== 1'b0) begin
        miscompares++; $display("FAIL directed_pulse: ready got %b want 0", bus8.ready);
      end
    end
  endtask

  // start held after ready must not restart; a 1-cycle drop then re-arms.
  task automatic test_hold_start();
    bit   ok;
    int   pulses;
    exp_t e;
    issue8(8'd7, 8'd5, 8'd13);
    wait_ready8(ok);
    e = q8.pop_front();
    vectors++;
    if (!ok || bus8.result !== 8'd9) begin
      miscompares++; $display("FAIL hold_first: ok=%b result got %0d want 9", ok, bus8.result);
    end
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus8.ready === 1'b1) pulses++;
    end
    $display("hold: start high 30 cycles after ready, extra pulses=%0d", pulses);
    vectors++;
    if (pulses != 0) begin
      miscompares++; $display("FAIL hold_extra_pulse: got %0d want 0", pulses);
    end
    bus8.start = 1'b0;
    @(negedge clk);
    issue8(8'd3, 8'd4, 8'd13);
    wait_ready8(ok);
    bus8.start = 1'b0;
    e = q8.pop_front();
    $display("op8 A=3 B=4 N=13 after rearm -> result=%0d lat=%0d", bus8.result, cyc - e.acc);
    vectors += 2;
    if (!ok || bus8.result !== e.res[7:0]) begin
      miscompares++; $display("FAIL hold_second_result: got %0d want %0d", bus8.result, e.res);
    end
    if (cyc - e.acc != e.lat) begin
      miscompares++; $display("FAIL hold_second_latency: got %0d want %0d", cyc - e.acc, e.lat);
    end
    @(negedge clk);
  endtask

  // Re-accept 2 cycles after ready, and start dropping mid-CALC still completes.
  task automatic test_back_to_back();
    bit   ok;
    int   r0;
    exp_t e;
    issue8(8'd11, 8'd6, 8'd17);
    wait_ready8(ok);
    bus8.start = 1'b0;
    e  = q8.pop_front();
    r0 = cyc;
    vectors++;
    if (!ok || bus8.result !== e.res[7:0]) begin
      miscompares++; $display("FAIL b2b_first: got %0d want %0d", bus8.result, e.res);
    end
    @(negedge clk);
    issue8(8'd10, 8'd10, 8'd17);
    repeat (4) @(negedge clk);
    bus8.start = 1'b0;
    wait_ready8(ok);
    e = q8.pop_front();
    $display("b2b: ready-to-ready gap=%0d result=%0d", cyc - r0, bus8.result);
    vectors += 2;
    if (!ok || bus8.result !== e.res[7:0]) begin
      miscompares++; $display("FAIL b2b_second_result: got %0d want %0d", bus8.result, e.res);
    end
    if (cyc - r0 != 2 + latency_for(W8)) begin
      miscompares++; $display("FAIL b2b_gap: got %0d want %0d", cyc - r0, 2 + latency_for(W8));
    end
    @(negedge clk);
  endtask

  // Asynchronous reset in the middle of CALC, then a clean operation.
  task automatic test_reset_mid();
    bit   ok;
    int   pulses;
    exp_t e;
    issue8(8'd9, 8'd8, 8'd13);
    repeat (5) @(negedge clk);
    bus8.start = 1'b0;
    e = q8.pop_front();
    vectors++;
    if (bus8.result === 8'd0) begin
      miscompares++; $display("FAIL reset_mid_precond: result got 0 want nonzero");
    end
    rst = 1'b1;
    #1;
    $display("reset mid-CALC: ready=%b err=%b result=%0d", bus8.ready, bus8.err, bus8.result);
    vectors += 2;
    if (bus8.ready !== 1'b0 || bus8.err !== 1'b0) begin
      miscompares++; $display("FAIL reset_mid_flags: ready=%b err=%b want 0 0", bus8.ready, bus8.err);
    end
    if (bus8.result !== 8'd0) begin
      miscompares++; $display("FAIL reset_mid_result: got %0d want 0", bus8.result);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus8.ready === 1'b1) pulses++;
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++; $display("FAIL reset_mid_stale_ready: got %0d want 0", pulses);
    end
    issue8(8'd12, 8'd12, 8'd13);
    wait_ready8(ok);
    bus8.start = 1'b0;
    e = q8.pop_front();
    $display("op8 A=12 B=12 N=13 after reset -> result=%0d lat=%0d", bus8.result, cyc - e.acc);
    vectors += 2;
    if (!ok || bus8.result !== e.res[7:0]) begin
      miscompares++; $display("FAIL reset_mid_next_result: got %0d want %0d", bus8.result, e.res);
    end
    if (cyc - e.acc != e.lat) begin
      miscompares++; $display("FAIL reset_mid_next_latency: got %0d want %0d", cyc - e.acc, e.lat);
    end
    @(negedge clk);
  endtask

  // Random 64-bit operands, alternating odd/even moduli of varied magnitude.
  task automatic test_random64();
    bit           ok;
    exp_t         e;
    logic [63:0]  n;
    logic [63:0]  a;
    logic [63:0]  b;
    logic [127:0] prod;
    for (int i = 0; i < 1000; i++) begin
      n    = {$urandom, $urandom} >> $urandom_range(0, 60);
      n[0] = i[0];
      if (n < 64'd2) n = 64'd2 + 64'(i[0]);
      a    = {$urandom, $urandom} % n;
      b    = {$urandom, $urandom} % n;
      prod = 128'(a) * 128'(b);
      e.a   = a;
      e.b   = b;
      e.n   = n;
      e.err = 1'b0;
      e.res = 64'(prod % 128'(n));
      e.lat = latency_for(W64);
      e.acc = cyc + 1;
      bus64.X_data = a;
      bus64.Y_data = b;
      bus64.N      = n;
      bus64.start  = 1'b1;
      q64.push_back(e);
      wait_ready64(ok);
      bus64.start = 1'b0;
      e = q64.pop_front();
      vectors++;
      if (!ok) begin
        miscompares++; $display("FAIL rand64_timeout: op %0d no ready within bound", i);
        @(negedge clk);
        continue;
      end
      $display("op64 %0d A=%h B=%h N=%h -> %h lat=%0d", i, e.a, e.b, e.n, bus64.result, cyc - e.acc);
      vectors += 3;
      if (bus64.result !== e.res) begin
        miscompares++; $display("FAIL rand64_result: got %h want %h", bus64.result, e.res);
      end
      if (bus64.err !== 1'b0) begin
        miscompares++; $display("FAIL rand64_err: got %b want 0", bus64.err);
      end
      if (cyc - e.acc != e.lat) begin
        miscompares++; $display("FAIL rand64_latency: got %0d want %0d", cyc - e.acc, e.lat);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    bus8.start   = 1'b0;
    bus8.X_data  = '0;
    bus8.Y_data  = '0;
    bus8.N       = '0;
    bus64.start  = 1'b0;
    bus64.X_data = '0;
    bus64.Y_data = '0;
    bus64.N      = '0;
    test_reset();
    test_directed();
    test_hold_start();
    test_back_to_back();
    test_reset_mid();
    test_random64();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
